// File: rtl/state_app_dispatcher.sv
// -----------------------------------------------------------------------------
// state_app_dispatcher
//
// Feeds lookups into the three-stage state_lookup_app chain. Two requester
// FIFOs (wildcard-match WC and exact-match EM) are served round-robin. Each
// lookup produces exactly one state_entry_vld pulse toward app1. A credit
// counter caps the number of lookups in flight at MAX_INFLIGHT, which must not
// exceed the result FIFO depth. A table_flush request first waits for every
// outstanding lookup to drain, then emits a single-cycle flush_go strobe.
//
// Optional feature macro: STATE_DISPATCH_STATS_EN
//   When defined, adds the wc_grant_cnt, em_grant_cnt and stall_cnt outputs.
//
// Parameters
//   ENTRY_W       state entry width      (STATE_TABLE_ENTRY_WIDTH in the system)
//   ACT_W         action word width      (OPENFLOW_ACTION_WIDTH)
//   PORT_W        source-port width      (OPENFLOW_ENTRY_SRC_PORT_WIDTH)
//   MAX_INFLIGHT  credit count, <= result FIFO depth
//
// Ports
//   clk                  core clock
//   reset                synchronous, active-low (0 = reset)
//   wc_empty / em_empty  requester FIFO empty flags
//   wc_rd_en / em_rd_en  requester FIFO pops (dout valid on the next cycle)
//   wc_* / em_*          entry, action and source port from the FIFO dout
//   state_entry          lookup key to app1 (holds the last issued value)
//   state_entry_vld      one-cycle issue strobe to app1
//   action_out           action to app1
//   src_port_out         source port to app1
//   result_rd_en         result FIFO pop; returns one credit
//   table_flush          flush request level, sampled in ARB
//   flush_go             one-cycle flush strobe to the app tables
//   credit_err           sticky: credit returned while none were outstanding
//   state_dbg            current FSM state, for debug and checkers
//   wc_grant_cnt, em_grant_cnt, stall_cnt  (STATE_DISPATCH_STATS_EN only)
//
// Handshake: a requester is "ready" when its empty flag is low. A pop is the
// single cycle rd_en is high; the FIFO presents the popped word on the next
// cycle, where FETCH captures it. state_entry_vld has no backpressure: the
// downstream chain accepts every issue strobe.
// -----------------------------------------------------------------------------
module state_app_dispatcher #(
  parameter int ENTRY_W      = 32,
  parameter int ACT_W        = 16,
  parameter int PORT_W       = 8,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wc_empty,
  input  logic              em_empty,
  output logic              wc_rd_en,
  output logic              em_rd_en,
  input  logic [ENTRY_W-1:0] wc_entry,
  input  logic [ENTRY_W-1:0] em_entry,
  input  logic [ACT_W-1:0]   wc_action,
  input  logic [ACT_W-1:0]   em_action,
  input  logic [PORT_W-1:0]  wc_port,
  input  logic [PORT_W-1:0]  em_port,
  output logic [ENTRY_W-1:0] state_entry,
  output logic              state_entry_vld,
  output logic [ACT_W-1:0]   action_out,
  output logic [PORT_W-1:0]  src_port_out,
  input  logic              result_rd_en,
  input  logic              table_flush,
  output logic              flush_go,
  output logic              credit_err,
  output logic [2:0]        state_dbg
`ifdef STATE_DISPATCH_STATS_EN
  ,
  output logic [31:0]       wc_grant_cnt,
  output logic [31:0]       em_grant_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  localparam logic [2:0] ST_ARB   = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] outstanding;
  logic             rr_last_em;  // 1: EM issued last, so WC has priority
  logic             grant_em;    // requester granted for the lookup in flight

  logic [ENTRY_W-1:0] entry_q;
  logic [ACT_W-1:0]   action_q;
  logic [PORT_W-1:0]  port_q;

  logic wc_req, em_req, any_req;
  logic credit_ok, can_grant, pick_em;
  logic issue, pop_ok;

  assign wc_req    = !wc_empty;
  assign em_req    = !em_empty;
  assign any_req   = wc_req || em_req;
  assign credit_ok = (outstanding < MAX_CNT);

  // A pending flush outranks new grants so the drain starts from a stable count.
  assign can_grant = (state == ST_ARB) && !table_flush && credit_ok && any_req;

  // EM wins when it is the only requester, or when both request and WC went last.
  assign pick_em = em_req && (!wc_req || !rr_last_em);

  assign issue  = (state == ST_ISSUE);
  assign pop_ok = result_rd_en && (outstanding != '0);

  // Strobes are gated by reset so nothing leaks out while reset is held low.
  assign wc_rd_en        = reset && can_grant && !pick_em;
  assign em_rd_en        = reset && can_grant &&  pick_em;
  assign state_entry_vld = reset && issue;
  assign flush_go        = reset && (state == ST_FLUSH);

  assign state_entry  = entry_q;
  assign action_out   = action_q;
  assign src_port_out = port_q;
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_ARB;
      rr_last_em <= 1'b1;
      grant_em   <= 1'b0;
      entry_q    <= '0;
      action_q   <= '0;
      port_q     <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (table_flush) begin
            state <= ST_DRAIN;
          end else if (can_grant) begin
            grant_em <= pick_em;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (grant_em) begin
            entry_q  <= em_entry;
            action_q <= em_action;
            port_q   <= em_port;
          end else begin
            entry_q  <= wc_entry;
            action_q <= wc_action;
            port_q   <= wc_port;
          end
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          rr_last_em <= grant_em;
          state      <= ST_ARB;
        end
        ST_DRAIN: begin
          if (outstanding == '0) state <= ST_FLUSH;
        end
        ST_FLUSH: state <= ST_ARB;
        default:  state <= ST_ARB;
      endcase
    end
  end

  // Credit accounting: an issue and a valid return in the same cycle cancel.
  // A return with nothing outstanding is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding <= '0;
      credit_err  <= 1'b0;
    end else begin
      case ({issue, pop_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (result_rd_en && (outstanding == '0)) credit_err <= 1'b1;
    end
  end

`ifdef STATE_DISPATCH_STATS_EN
  logic stall;
  assign stall = (state == ST_ARB) && !table_flush && !credit_ok && any_req;

  always_ff @(posedge clk) begin
    if (!reset || (state == ST_FLUSH)) begin
      wc_grant_cnt <= '0;
      em_grant_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (issue && !grant_em) wc_grant_cnt <= wc_grant_cnt + 32'd1;
      if (issue &&  grant_em) em_grant_cnt <= em_grant_cnt + 32'd1;
      if (stall)              stall_cnt    <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_state_app_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_state_app_dispatcher
//
// Directed bench for state_app_dispatcher. Two queue-backed FIFO models feed
// the requester ports; an expected queue holds the entries in the order they
// must be issued. Inputs are driven 1 time unit after the rising edge, outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_state_app_dispatcher;

  localparam int ENTRY_W = 32;
  localparam int ACT_W   = 16;
  localparam int PORT_W  = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic               wc_empty, em_empty;
  logic               wc_rd_en, em_rd_en;
  logic [ENTRY_W-1:0] wc_entry, em_entry;
  logic [ACT_W-1:0]   wc_action, em_action;
  logic [PORT_W-1:0]  wc_port, em_port;
  logic [ENTRY_W-1:0] state_entry;
  logic               state_entry_vld;
  logic [ACT_W-1:0]   action_out;
  logic [PORT_W-1:0]  src_port_out;
  logic               result_rd_en;
  logic               table_flush;
  logic               flush_go;
  logic               credit_err;
  logic [2:0]         state_dbg;
`ifdef STATE_DISPATCH_STATS_EN
  logic [31:0]        wc_grant_cnt, em_grant_cnt, stall_cnt;
`endif

  state_app_dispatcher #(
    .ENTRY_W(ENTRY_W), .ACT_W(ACT_W), .PORT_W(PORT_W), .MAX_INFLIGHT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .wc_empty(wc_empty), .em_empty(em_empty),
    .wc_rd_en(wc_rd_en), .em_rd_en(em_rd_en),
    .wc_entry(wc_entry), .em_entry(em_entry),
    .wc_action(wc_action), .em_action(em_action),
    .wc_port(wc_port), .em_port(em_port),
    .state_entry(state_entry), .state_entry_vld(state_entry_vld),
    .action_out(action_out), .src_port_out(src_port_out),
    .result_rd_en(result_rd_en), .table_flush(table_flush),
    .flush_go(flush_go), .credit_err(credit_err), .state_dbg(state_dbg)
`ifdef STATE_DISPATCH_STATS_EN
    , .wc_grant_cnt(wc_grant_cnt), .em_grant_cnt(em_grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Action and port are derived from the entry so one queue describes a word.
  assign wc_action = wc_entry[15:0] ^ 16'h5a5a;
  assign em_action = em_entry[15:0] ^ 16'h5a5a;
  assign wc_port   = wc_entry[7:0] + 8'd1;
  assign em_port   = em_entry[7:0] + 8'd1;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- FIFO models ----------------
  logic [ENTRY_W-1:0] wc_q[$];
  logic [ENTRY_W-1:0] em_q[$];
  logic wc_pend = 1'b0;
  logic em_pend = 1'b0;

  task automatic push_wc(input logic [ENTRY_W-1:0] v);
    wc_q.push_back(v);
    wc_empty = 1'b0;
  endtask

  task automatic push_em(input logic [ENTRY_W-1:0] v);
    em_q.push_back(v);
    em_empty = 1'b0;
  endtask

  // A pop seen during a cycle updates dout and empty just after the edge.
  always @(posedge clk) begin
    #1;
    if (wc_pend) begin
      wc_entry = wc_q.pop_front();
      wc_pend  = 1'b0;
    end
    if (em_pend) begin
      em_entry = em_q.pop_front();
      em_pend  = 1'b0;
    end
    wc_empty = (wc_q.size() == 0);
    em_empty = (em_q.size() == 0);
  end

  // ---------------- scoreboard / monitor ----------------
  logic [ENTRY_W-1:0] exp_q[$];
  int                 pop_cyc_q[$];
  logic [ENTRY_W-1:0] last_exp = '0;
  int cycle     = 0;
  int vld_cnt   = 0;
  int flush_cnt = 0;
  int pop_cnt   = 0;

  always @(negedge clk) begin
    cycle++;
    check("rd_onehot", {63'd0, wc_rd_en & em_rd_en}, 64'd0);
    check("rd_when_empty", {63'd0, (wc_rd_en & wc_empty) | (em_rd_en & em_empty)}, 64'd0);
    if (!reset) begin
      check("rst_quiet", {60'd0, wc_rd_en, em_rd_en, state_entry_vld, flush_go}, 64'd0);
      if (cycle > 1) check("rst_entry", {32'd0, state_entry}, 64'd0);
    end
    if (wc_rd_en || em_rd_en) begin
      pop_cnt++;
      pop_cyc_q.push_back(cycle);
      if (wc_rd_en) wc_pend = 1'b1;
      if (em_rd_en) em_pend = 1'b1;
    end
    if (flush_go) flush_cnt++;
    if (state_entry_vld) begin
      vld_cnt++;
      if (pop_cyc_q.size() == 0) begin
        check("vld_without_rd", 64'd1, 64'd0);
      end else begin
        check("latency", 64'(cycle - pop_cyc_q.pop_front()), 64'd2);
      end
      if (exp_q.size() == 0) begin
        check("vld_unexpected", 64'd1, 64'd0);
      end else begin
        last_exp = exp_q.pop_front();
        check("entry", {32'd0, state_entry}, {32'd0, last_exp});
        check("action", {48'd0, action_out}, {48'd0, last_exp[15:0] ^ 16'h5a5a});
        check("port", {56'd0, src_port_out}, {56'd0, last_exp[7:0] + 8'd1});
      end
    end else if (reset && vld_cnt > 0) begin
      check("entry_hold", {32'd0, state_entry}, {32'd0, last_exp});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (vld_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, {63'd0, vld_cnt >= n}, 64'd1);
  endtask

  task automatic pulse_result(input int n);
    for (int i = 0; i < n; i++) begin
      result_rd_en = 1'b1;
      tick();
    end
    result_rd_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int base_vld, base_pop, base_flush;
  logic [ENTRY_W-1:0] v;

  initial begin
    reset        = 1'b0;
    result_rd_en = 1'b0;
    table_flush  = 1'b0;
    wc_empty     = 1'b1;
    em_empty     = 1'b1;
    wc_entry     = '0;
    em_entry     = '0;

    // Reset held with both FIFOs loaded: nothing may move.
    for (int i = 0; i < 3; i++) begin
      v = 32'h100 + 32'(i); push_wc(v);
      v = 32'h200 + 32'(i); push_em(v);
    end
    repeat (6) tick();
    check("rst_vld_cnt", 64'(vld_cnt), 64'd0);
    check("rst_pop_cnt", 64'(pop_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    check("rst_credit_err", {63'd0, credit_err}, 64'd0);

    // Round robin with credits returned every cycle; WC goes first.
    for (int i = 0; i < 3; i++) begin
      v = 32'h100 + 32'(i); exp_q.push_back(v);
      v = 32'h200 + 32'(i); exp_q.push_back(v);
    end
    reset        = 1'b1;
    result_rd_en = 1'b1;
    tick();
    // Credit returned with none outstanding on the first cycle out of reset.
    check("credit_err_set", {63'd0, credit_err}, 64'd1);
    wait_vld("rr_done", 6, 100);
    check("rr_exp_empty", 64'(exp_q.size()), 64'd0);
    check("rr_pops", 64'(pop_cnt), 64'd6);
`ifdef STATE_DISPATCH_STATS_EN
    check("stat_wc_grants", {32'd0, wc_grant_cnt}, 64'd3);
    check("stat_em_grants", {32'd0, em_grant_cnt}, 64'd3);
`endif
    repeat (3) tick();
    result_rd_en = 1'b0;
    repeat (2) tick();

    // Credit limit: ten WC entries, no returns -> eight issues then stall.
    base_vld = vld_cnt;
    base_pop = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      v = 32'h300 + 32'(i);
      push_wc(v);
      exp_q.push_back(v);
    end
    wait_vld("credit_fill", base_vld + 8, 100);
    repeat (30) tick();
    check("credit_cap_vld", 64'(vld_cnt - base_vld), 64'd8);
    check("credit_cap_rd", 64'(pop_cnt - base_pop), 64'd8);
`ifdef STATE_DISPATCH_STATS_EN
    check("stat_stall_nz", {63'd0, stall_cnt != 32'd0}, 64'd1);
`endif
    pulse_result(1);
    repeat (20) tick();
    check("one_more_issue", 64'(vld_cnt - base_vld), 64'd9);

    // Return a credit in the very cycle of an issue: count must stay at 7.
    pulse_result(1);
    for (int k = 0; k < 20; k++) begin
      if (state_entry_vld) break;
      tick();
    end
    check("sameclk_vld_seen", {63'd0, state_entry_vld}, 64'd1);
    pulse_result(1);
    v = 32'h30a; push_wc(v); exp_q.push_back(v);
    repeat (20) tick();
    check("sameclk_issues", 64'(vld_cnt - base_vld), 64'd11);
    check("credit_exp_empty", 64'(exp_q.size()), 64'd0);

    // Drain: bring outstanding to 3, pulse flush with EM work waiting.
    pulse_result(5);
    base_pop   = pop_cnt;
    base_flush = flush_cnt;
    base_vld   = vld_cnt;
    v = 32'h400; push_em(v); exp_q.push_back(v);
    v = 32'h401; push_em(v); exp_q.push_back(v);
    table_flush = 1'b1;
    tick();
    table_flush = 1'b0;
    repeat (5) tick();
    check("drain_no_rd", 64'(pop_cnt - base_pop), 64'd0);
    check("drain_no_flush", 64'(flush_cnt - base_flush), 64'd0);
    pulse_result(2);
    repeat (4) tick();
    check("drain_wait", 64'(flush_cnt - base_flush), 64'd0);
    check("drain_still_no_rd", 64'(pop_cnt - base_pop), 64'd0);
    pulse_result(1);
    for (int k = 0; k < 10; k++) begin
      if (flush_cnt != base_flush) break;
      tick();
    end
    check("flush_fired", 64'(flush_cnt - base_flush), 64'd1);
`ifdef STATE_DISPATCH_STATS_EN
    check("stat_clr_wc", {32'd0, wc_grant_cnt}, 64'd0);
    check("stat_clr_em", {32'd0, em_grant_cnt}, 64'd0);
    check("stat_clr_stall", {32'd0, stall_cnt}, 64'd0);
`endif
    wait_vld("resume", base_vld + 2, 50);
    repeat (10) tick();
    check("flush_once", 64'(flush_cnt - base_flush), 64'd1);
    check("resume_exp_empty", 64'(exp_q.size()), 64'd0);
    check("credit_err_sticky", {63'd0, credit_err}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
